// File: rtl/segre_core_ctrl.sv
// Multi-cycle Segre core sequencer: IF/ID/EX/MEM/WB stepping, memory watchdog, debug halt.
// Optional performance counters are built when SEGRE_PERF_CNT_EN is defined.

package segre_pkg;
  typedef enum logic [2:0] {
    IF_STATE  = 3'd0,
    ID_STATE  = 3'd1,
    EX_STATE  = 3'd2,
    MEM_STATE = 3'd3,
    WB_STATE  = 3'd4
  } fsm_state_e;
endpackage

// state     | meaning
// IF_STATE  | fetch request outstanding; also the parked state while halted
// ID_STATE  | decode, illegal-instruction check
// EX_STATE  | execute, choose MEM or WB
// MEM_STATE | data access outstanding
// WB_STATE  | writeback / PC update, debug-halt sample point
module segre_core_ctrl
  import segre_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  output fsm_state_e  fsm_state_o,
  output logic        mem_req_o,
  input  logic        mem_ready_i,
  input  logic        mem_op_i,
  input  logic        illegal_instr_i,
  output logic        wb_en_o,
  input  logic        dbg_halt_i,
  input  logic        dbg_resume_i,
  output logic        halt_o,
  output logic [1:0]  halt_cause_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_DBG  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  fsm_state_e        state_q, state_d;
  logic              halted_q, halted_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wait_expired;

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    cause_d      = cause_q;
    wait_d       = wait_q;
    wait_expired = (MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST) && !mem_ready_i;

    if (halted_q) begin
      // Only a debug halt is resumable; illegal and timeout halts need a reset.
      state_d = IF_STATE;
      if (dbg_resume_i && (cause_q == CAUSE_DBG)) begin
        halted_d = 1'b0;
        cause_d  = CAUSE_NONE;
        wait_d   = '0;
      end
    end else begin
      unique case (state_q)
        IF_STATE, MEM_STATE: begin
          if (mem_ready_i) begin
            state_d = (state_q == IF_STATE) ? ID_STATE : WB_STATE;
          end else if (wait_expired) begin
            halted_d = 1'b1;
            cause_d  = CAUSE_TMO;
            state_d  = IF_STATE;
            wait_d   = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ID_STATE: begin
          if (illegal_instr_i) begin
            halted_d = 1'b1;
            cause_d  = CAUSE_ILL;
            state_d  = IF_STATE;
          end else begin
            state_d = EX_STATE;
          end
        end
        EX_STATE: begin
          if (mem_op_i) begin
            state_d = MEM_STATE;
            wait_d  = '0;
          end else begin
            state_d = WB_STATE;
          end
        end
        WB_STATE: begin
          // The instruction retires regardless; the debug halt takes effect afterwards.
          state_d = IF_STATE;
          wait_d  = '0;
          if (dbg_halt_i) begin
            halted_d = 1'b1;
            cause_d  = CAUSE_DBG;
          end
        end
        default: begin
          state_d = IF_STATE;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q  <= IF_STATE;
      halted_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cause_q  <= cause_d;
      wait_q   <= wait_d;
    end
  end

  assign fsm_state_o  = state_q;
  assign halt_o       = halted_q;
  assign halt_cause_o = cause_q;
  assign mem_req_o    = rsn_i && !halted_q && ((state_q == IF_STATE) || (state_q == MEM_STATE));
  assign wb_en_o      = rsn_i && !halted_q && (state_q == WB_STATE);

`ifdef SEGRE_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_q, instret_d;
  logic        retire;

  assign retire = (state_q == WB_STATE) && !halted_q;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 64'd1;
    instret_d   = retire ? instret_q + 64'd1 : instret_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif

endmodule

// File: doc/segre_core_ctrl.md
# segre_core_ctrl

Main sequencer for the multi-cycle Segre core. It drives the shared `fsm_state_e` state (IF_STATE, ID_STATE, EX_STATE, MEM_STATE, WB_STATE) consumed by the fetch, decode, execute, memory and writeback stages. It stalls on the single memory port's handshake and skips MEM_STATE for non-memory instructions. It also stops the core on an illegal instruction, a memory watchdog timeout or a debug request.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum consecutive wait cycles for `mem_ready_i`. 0 disables the watchdog.

Ports (reset is synchronous, active-low, sampled on `posedge clk_i`):
- `clk_i`  in  1  core clock
- `rsn_i`  in  1  synchronous active-low reset
- `fsm_state_o`  out  fsm_state_e  current core state, broadcast to all stages
- `mem_req_o`  out  1  memory access request (fetch in IF_STATE, data in MEM_STATE)
- `mem_ready_i`  in  1  memory completed the current access this cycle
- `mem_op_i`  in  1  decoded instruction is a load/store; sampled in EX_STATE
- `illegal_instr_i`  in  1  decode flags an illegal instruction; sampled in ID_STATE
- `wb_en_o`  out  1  one-cycle writeback/PC-update enable
- `dbg_halt_i`  in  1  debug halt request (level)
- `dbg_resume_i`  in  1  resume from a debug halt
- `halt_o`  out  1  core halted
- `halt_cause_o`  out  2  00 none, 01 debug, 10 illegal instruction, 11 memory timeout
- `cycle_cnt_o`  out  64  cycles since reset (see Configuration)
- `instret_o`  out  64  retired instructions (see Configuration)

## Operation
- State register holds `fsm_state_e`, plus a `halted` flag and a wait counter of width `$clog2(MEM_TIMEOUT+1)`.
- IF_STATE: `mem_req_o`=1. On `mem_ready_i`=1, go to ID_STATE. Otherwise increment the wait counter.
- ID_STATE: one cycle. If `illegal_instr_i`, set `halted`, cause=10, and go to IF_STATE. Otherwise go to EX_STATE.
- EX_STATE: one cycle. If `mem_op_i`, go to MEM_STATE. Otherwise go to WB_STATE.
- MEM_STATE: `mem_req_o`=1. On `mem_ready_i`, go to WB_STATE. Otherwise increment the wait counter.
- WB_STATE: `wb_en_o`=1 for exactly this cycle. `instret` increments. Next state is IF_STATE.
- Watchdog: the wait counter clears on entry to IF_STATE/MEM_STATE. If `MEM_TIMEOUT`>0 and the counter equals `MEM_TIMEOUT`-1 with `mem_ready_i`=0, then on the next edge set `halted`, cause=11, and state becomes IF_STATE.
- Ready and timeout in the same cycle: ready wins, no halt.
- Debug halt:
  - `dbg_halt_i` is sampled only in WB_STATE.
  - If high there, the instruction still retires, then state becomes IF_STATE with `halted` set and cause=01.
  - An in-flight instruction is never aborted.
- While halted:
  - `fsm_state_o`=IF_STATE, `mem_req_o`=0, `wb_en_o`=0, no state advance.
  - The cycle counter keeps counting.
- Resume:
  - `dbg_resume_i`=1 while halted with cause=01 clears `halted` and sets cause=00. Fetch restarts next cycle.
  - `dbg_resume_i` is ignored for causes 10 and 11; only reset clears those.
- `halt_o` = `halted` (registered).

## Timing
- Reset (`rsn_i`=0 at an edge):
  - next cycle: `fsm_state_o`=IF_STATE, `halt_o`=0, `halt_cause_o`=00, `cycle_cnt_o`=0, `instret_o`=0, wait counter=0.
  - While `rsn_i`=0: `mem_req_o`=0 and `wb_en_o`=0 (combinational gate).
- Reset mid-operation abandons the access. The first cycle after reset release is IF_STATE with `mem_req_o`=1.
- `mem_req_o` and `wb_en_o` are combinational from the state register and `halted`. All other outputs are registered.
- Latency with zero-wait memory: ALU instruction 4 cycles (IF, ID, EX, WB); load/store 5 cycles. Each memory wait cycle adds 1.
- Counters are 64-bit unsigned and wrap from 2^64-1 to 0.

## Configuration
- `SEGRE_PERF_CNT_EN` defined:
  - `cycle_cnt_o` increments every cycle after reset.
  - `instret_o` increments on each WB_STATE cycle.
- Not defined:
  - Both counters are absent and the outputs are tied to 0.
  - Control behaviour is identical.

## Test plan
- Reset, then ALU instruction with `mem_ready_i` high in IF: states are IF, ID, EX, WB, IF. `wb_en_o` is high one cycle in WB. `instret_o`=1.
- Load with `mem_ready_i` delayed 3 cycles in IF and 2 in MEM: 10 cycles to retire. `mem_req_o` is high throughout both waits. No halt.
- `MEM_TIMEOUT`=4, `mem_ready_i` held low in MEM: after 4 MEM cycles, `halt_o`=1 and `halt_cause_o`=11. `mem_req_o`=0 after that. `dbg_resume_i` has no effect.
- `mem_ready_i` asserted in the 4th wait cycle with `MEM_TIMEOUT`=4: advances normally, `halt_o` stays 0.
- `illegal_instr_i`=1 in ID: next cycle `halt_o`=1, cause=10. `wb_en_o` never asserts and `instret_o` is unchanged.
- `dbg_halt_i`=1 during EX of a load: instruction completes through WB (`instret_o`+1), then halt with cause=01. `dbg_resume_i` clears it and the next cycle has `mem_req_o`=1. Mid-run reset returns all outputs to reset values.
